// File: rtl/dtfag_stream_agu.sv
// dtfag_stream_agu: pipelined twiddle-factor address generator with credit-protected FWFT output FIFO
// Ports: clk/rst_n (async active-low); in_valid/in_ready + DTFAG_i/t/j request handshake;
// rom_cen (active-low, per level), rom_addr, rom_rdata to/from external ROM macros;
// out_valid/out_ready/out_data concatenated ROM words, level k in lane k.
// Optional macro DTFAG_ZERO_SKIP_EN: zero digits skip their ROM read and return ONE_VAL.
module dtfag_stream_agu #(
  parameter int RADIX_W = 4,
  parameter int NUM_ROM = 3,
  parameter int D_W = 64,
  parameter int ROM_LAT = 1,
  parameter int FIFO_DEPTH = 4,
  parameter logic [D_W-1:0] ONE_VAL = {{(D_W-1){1'b0}}, 1'b1}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RADIX_W-1:0]       DTFAG_i,
  input  logic [RADIX_W-1:0]       DTFAG_t,
  input  logic [RADIX_W-1:0]       DTFAG_j,
  output logic [NUM_ROM-1:0]       rom_cen,
  output logic [NUM_ROM*RADIX_W-1:0] rom_addr,
  input  logic [NUM_ROM*D_W-1:0]   rom_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_ROM*D_W-1:0]   out_data
);
  localparam int AW = NUM_ROM * RADIX_W;
  localparam int PX = 3 * RADIX_W;
  localparam int DW = NUM_ROM * D_W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [PX-1:0] p3;
  logic [AW-1:0] s1_p;
  logic s1_v, acc, pop, wr;
  logic [NUM_ROM-1:0] zmask;
  logic [ROM_LAT-1:0] vpipe;
  logic [NUM_ROM-1:0] zpipe [ROM_LAT];
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt, credit, c_next;
  assign p3 = PX'(DTFAG_i) * PX'({DTFAG_t, DTFAG_j});
`ifdef DTFAG_ZERO_SKIP_EN
  always_comb begin
    zmask = '0;
    for (int k = 0; k < NUM_ROM; k++) zmask[k] = s1_p[k*RADIX_W +: RADIX_W] == '0;
  end
`else
  assign zmask = '0;
`endif
  // rom_addr follows the S1 register, so it holds the last request between reads
  assign rom_addr = s1_p;
  assign rom_cen = s1_v ? zmask : '1;
  assign wr = vpipe[ROM_LAT-1];
  assign acc = in_valid & in_ready;
  assign out_valid = cnt != '0;
  assign pop = out_valid & out_ready;
  // credit covers S1, the ROM pipe and the FIFO, so every issued read owns a slot
  assign c_next = credit + CW'(acc) - CW'(pop);
  assign out_data = out_valid ? mem[rptr] : '0;
  always_comb begin
    wdata = rom_rdata;
    for (int k = 0; k < NUM_ROM; k++)
      if (zpipe[ROM_LAT-1][k]) wdata[k*D_W +: D_W] = ONE_VAL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_ready <= 1'b0;
      credit <= '0;
      s1_v <= 1'b0;
      s1_p <= '0;
      vpipe <= '0;
      for (int n = 0; n < ROM_LAT; n++) zpipe[n] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      in_ready <= c_next < CW'(FIFO_DEPTH);
      credit <= c_next;
      s1_v <= acc;
      if (acc) s1_p <= AW'(p3);
      vpipe[0] <= s1_v;
      zpipe[0] <= zmask;
      for (int n = 1; n < ROM_LAT; n++) begin
        vpipe[n] <= vpipe[n-1];
        zpipe[n] <= zpipe[n-1];
      end
      if (wr) wptr <= wptr == PW'(FIFO_DEPTH - 1) ? '0 : wptr + 1'b1;
      if (pop) rptr <= rptr == PW'(FIFO_DEPTH - 1) ? '0 : rptr + 1'b1;
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= wdata;
endmodule

// File: tb/tb_dtfag_stream_agu.sv
// tb_dtfag_stream_agu: table-driven and scoreboard bench for dtfag_stream_agu
module tb_dtfag_stream_agu;
  localparam int RW = 4;
  localparam int NR = 3;
  localparam int DW = 64;
`ifdef DTFAG_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef struct {
    logic [RW-1:0] i, t, j;
    logic [NR*RW-1:0] addr;
    logic [NR-1:0] zcen;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [RW-1:0] ti = '0, tt = '0, tj = '0;
  logic [NR-1:0] rom_cen, cen_s = '1;
  logic [NR*RW-1:0] rom_addr, addr_s = '0;
  logic [NR*DW-1:0] rom_rdata = '0, out_data;
  logic [NR*DW-1:0] sb [$];
  vec_t tbl [7];
  int n_vec = 0, n_err = 0, n_acc = 0, n_pop = 0, cyc = 0, last_pop = -10, runs = 0;
  int a0, p0, r0;
  always #5 clk = ~clk;
  dtfag_stream_agu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .DTFAG_i(ti), .DTFAG_t(tt), .DTFAG_j(tj), .rom_cen(rom_cen), .rom_addr(rom_addr),
    .rom_rdata(rom_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  function automatic logic [DW-1:0] rom_word(input int k, input logic [RW-1:0] a);
    return {16'hC0DE, k[7:0], 36'h0, a};
  endfunction
  function automatic logic [NR*DW-1:0] expect_out(input logic [RW-1:0] i, t, j);
    logic [NR*DW-1:0] r;
    logic [11:0] p;
    logic [3:0] d;
    p = 12'(i) * {4'h0, t, j};
    for (int k = 0; k < NR; k++) begin
      d = p[k*4 +: 4];
      r[k*DW +: DW] = (SKIP && d == 4'h0) ? 64'd1 : rom_word(k, d);
    end
    return r;
  endfunction
  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    cen_s = rom_cen;
    addr_s = rom_addr;
  end
  always @(posedge clk)
    for (int k = 0; k < NR; k++)
      rom_rdata[k*DW +: DW] <= !cen_s[k] ? rom_word(k, addr_s[k*RW +: RW]) : {16'hDEAD, 48'h0};
  always @(negedge clk)
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(expect_out(ti, tt, tj));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("pop_with_empty_scoreboard", 32'(sb.size()), 1);
        else check("out_data", out_data, sb.pop_front());
        if (cyc != last_pop + 1) runs++;
        last_pop = cyc;
        n_pop++;
      end
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [RW-1:0] i, t, j);
    in_valid = 1'b1;
    ti = i;
    tt = t;
    tj = j;
  endtask
  task automatic drain;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 40 && (sb.size() != 0 || out_valid); n++) tick;
    @(negedge clk);
    check("drain_scoreboard_empty", 32'(sb.size()), 0);
    check("drain_out_valid", out_valid, 0);
  endtask
  task automatic run_vec(input vec_t v);
    req(v.i, v.t, v.j);
    out_ready = 1'b1;
    @(negedge clk);
    check("vec_in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    check("vec_rom_cen", rom_cen, SKIP ? v.zcen : 3'b000);
    check("vec_rom_addr", rom_addr, v.addr);
    check("vec_lat1_out_valid", out_valid, 0);
    tick;
    @(negedge clk);
    check("vec_cen_one_cycle", rom_cen, 3'b111);
    check("vec_lat2_out_valid", out_valid, 0);
    tick;
    @(negedge clk);
    check("vec_lat3_out_valid", out_valid, 1);
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{4'd3, 4'd2, 4'd5, 12'h06F, 3'b100};
    tbl[1] = '{4'd15, 4'd15, 4'd15, 12'hEF1, 3'b000};
    tbl[2] = '{4'd0, 4'd7, 4'd7, 12'h000, 3'b111};
    tbl[3] = '{4'd1, 4'd0, 4'd1, 12'h001, 3'b110};
    tbl[4] = '{4'd2, 4'd8, 4'd0, 12'h100, 3'b011};
    tbl[5] = '{4'd7, 4'd9, 4'd9, 12'h42F, 3'b000};
    tbl[6] = '{4'd9, 4'd10, 4'd11, 12'h603, 3'b010};
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_rom_cen", rom_cen, 3'b111);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    #20 rst_n = 1'b1;
    tick;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    tick;
    foreach (tbl[v]) run_vec(tbl[v]);
    drain;
    tick;
    r0 = runs;
    a0 = n_acc;
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      req(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      @(negedge clk);
      check("b2b_in_ready", in_ready, 1);
      tick;
    end
    drain;
    check("b2b_accepts", n_acc - a0, 16);
    check("b2b_one_pop_run", runs - r0, 1);
    tick;
    out_ready = 1'b0;
    a0 = n_acc;
    for (int n = 0; n < 8; n++) begin
      req(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick;
    end
    @(negedge clk);
    check("bp_accepts", n_acc - a0, 4);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    tick;
    p0 = n_pop;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      req(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick;
    end
    @(negedge clk);
    check("bp_one_pop", n_pop - p0, 1);
    check("bp_one_refill", n_acc - a0, 5);
    check("bp_in_ready_again", in_ready, 0);
    drain;
    tick;
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      req(4'(n + 1), 4'd3, 4'd4);
      tick;
    end
    in_valid = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    check("c3_in_ready", in_ready, 1);
    check("c3_out_valid", out_valid, 1);
    tick;
    p0 = n_pop;
    a0 = n_acc;
    req(4'd6, 4'd1, 4'd2);
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("c3_same_cycle_in_ready", in_ready, 1);
    check("c3_pop_and_accept", (n_pop - p0) * 16 + (n_acc - a0), 17);
    tick;
    req(4'd5, 4'd5, 4'd5);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    check("c3_full_in_ready", in_ready, 0);
    drain;
    tick;
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      req(4'd5, 4'd3, 4'(n + 3));
      tick;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_rom_cen", rom_cen, 3'b111);
    check("mid_rst_rom_addr", rom_addr, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick;
      @(negedge clk);
      check("post_mid_rst_no_stale", out_valid, 0);
      check("post_mid_rst_in_ready", in_ready, 1);
    end
    tick;
    run_vec(tbl[0]);
    drain;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
